// File: rtl/digdug_spatr_pkg.sv
// Shared sizes, bank numbering and copy-FSM states for the DigDug sprite attribute RAM.
package digdug_spatr_pkg;

   localparam int NENT = 128;
   localparam int IDXW = 7;

   typedef enum logic [1:0] {
      BK_CODE = 2'd0,
      BK_POS  = 2'd1,
      BK_FLIP = 2'd2
   } bank_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_COPY,
      S_FLUSH
   } state_e;

endpackage

// File: rtl/digdug_spatr_bank.sv
// One 128x8 attribute bank: read/write port A on a shared address plus a read-only port B,
// both with a registered read. Contents are never reset; only the read registers are.
module digdug_spatr_bank
   import digdug_spatr_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we_a,
   input  logic [IDXW-1:0] addr_a,
   input  logic [7:0]      wdata_a,
   output logic [7:0]      rdata_a,
   input  logic [IDXW-1:0] addr_b,
   output logic [7:0]      rdata_b
);

   logic [7:0] mem [NENT];

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
   end

   // Reads sample the array before this edge's write lands (read-before-write).
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_a <= '0;
         rdata_b <= '0;
      end else begin
         rdata_a <= mem[addr_a];
         rdata_b <= mem[addr_b];
      end
   end

endmodule

// File: rtl/digdug_spatr_ram.sv
// Sprite attribute table: CPU-owned working banks, shadow banks copied on each VBLANK edge,
// and a 24-bit renderer read port that only ever sees complete frames.
module digdug_spatr_ram
   import digdug_spatr_pkg::*;
#(
   parameter int CPYDLY = 0
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        VBLANK,
   input  logic        CPUWE,
   input  logic [8:0]  CPUAD,
   input  logic [7:0]  CPUDI,
   output logic [7:0]  CPUDO,
   input  logic [6:0]  SPATAD,
   output logic [23:0] SPATDT,
   output logic        CPYBUSY
);

   localparam logic [3:0] DLY = 4'(CPYDLY);

   state_e          state, state_nxt;
   logic            vbl_q, start;
   logic [3:0]      cnt;
   logic [IDXW-1:0] idx, idx_q;
   logic            b_vld, a_fire;
   logic [1:0]      cpu_bk, bk_q;
   logic            cpu_wr;
   logic [2:0][7:0] wk_cpu, wk_cpy, unused_sh;

   assign cpu_bk = CPUAD[8:7];
   assign cpu_wr = CPUWE && (cpu_bk <= BK_FLIP);
   assign start  = VBLANK && !vbl_q;

   for (genvar g = 0; g < 3; g++) begin : g_bank
      digdug_spatr_bank u_work (
         .clk(CLK), .rst(RESET),
         .we_a(cpu_wr && (cpu_bk == 2'(g))), .addr_a(CPUAD[6:0]), .wdata_a(CPUDI),
         .rdata_a(wk_cpu[g]),
         .addr_b(idx), .rdata_b(wk_cpy[g])
      );
      digdug_spatr_bank u_shad (
         .clk(CLK), .rst(RESET),
         .we_a(b_vld), .addr_a(idx_q), .wdata_a(wk_cpy[g]), .rdata_a(unused_sh[g]),
         .addr_b(SPATAD), .rdata_b(SPATDT[8*g +: 8])
      );
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (start) state_nxt = (DLY == 4'd0) ? S_COPY : S_WAIT;
         S_WAIT:  if (cnt <= 4'd1) state_nxt = S_COPY;
         S_COPY:  if (a_fire && idx == IDXW'(NENT-1)) state_nxt = S_FLUSH;
         S_FLUSH: state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // CPU writes own the working banks; stage A only advances on cycles without one.
   always_comb begin
      CPYBUSY = (state != S_IDLE);
      a_fire  = (state == S_COPY) && !cpu_wr;
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         vbl_q <= 1'b0;
         cnt   <= '0;
         idx   <= '0;
         idx_q <= '0;
         b_vld <= 1'b0;
         bk_q  <= '0;
      end else begin
         vbl_q <= VBLANK;
         bk_q  <= cpu_bk;
         b_vld <= a_fire;
         cnt   <= (state == S_WAIT) ? cnt - 4'd1 : DLY;
         if (state == S_IDLE) begin
            idx <= '0;
         end else if (a_fire) begin
            idx_q <= idx;
            if (idx != IDXW'(NENT-1)) idx <= idx + IDXW'(1);
         end
      end
   end

   always_comb begin
      CPUDO = 8'h00;
      case (bk_q)
         BK_CODE: CPUDO = wk_cpu[0];
         BK_POS:  CPUDO = wk_cpu[1];
         BK_FLIP: CPUDO = wk_cpu[2];
         default: CPUDO = 8'h00;
      endcase
   end

endmodule
